seven_segment_bank: RTL and testbench

- Parametrised multi-digit hexadecimal display driver. It holds a NUM_DIGITS-nibble value captured on a load strobe and drives NUM_DIGITS active-low seven-segment displays in parallel from registered outputs.
- Adds leading-zero blanking, per-digit enables and an optional blink function.
- Sits between the memory-mapped LCD/HEX I/O registers and the board HEX pins.

---
 rtl/seven_seg_pkg.sv | 19 +
 rtl/hex_to_seg.sv | 11 +
 rtl/seven_segment_bank.sv | 114 +++++++++++
 tb/tb_seven_segment_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared widths, segment type and the hex glyph table for the seven-segment bank.
// Segment bit order is g..a, active low.
package seven_seg_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t GLYPH_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-glyph decoder, one instance per displayed digit.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output seg_t                o_seg
);

    assign o_seg = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/seven_segment_bank.sv
// Multi-digit hex display driver with leading-zero blanking and per-digit enables.
// Defining SEVEN_SEG_BLINK_EN adds i_blink_mask and a free-running blink timer.
module seven_segment_bank
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_data,
    input  logic                         i_load,
    input  logic                         i_lz_blank,
    input  logic [NUM_DIGITS-1:0]        i_digit_en,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]        i_blink_mask,
`endif
    output logic [SEG_W*NUM_DIGITS-1:0]  o_seg,
    output logic                         o_update
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_DIV < 2) begin : g_bad_params
        $error("seven_segment_bank: NUM_DIGITS must be 1..8 and BLINK_DIV >= 2");
    end

    logic [NIBBLE_W*NUM_DIGITS-1:0] data_q, data_d;
    logic [SEG_W*NUM_DIGITS-1:0]    seg_q, seg_d;
    logic                           pend_q, pend_d;
    logic                           update_q, update_d;
    seg_t                           glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]          lz_blank;
    logic [NUM_DIGITS-1:0]          blink_off;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
        hex_to_seg u_hex_to_seg (
            .i_nibble (data_q[k*NIBBLE_W +: NIBBLE_W]),
            .o_seg    (glyph[k])
        );
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        logic zero_above;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above && (data_q[k*NIBBLE_W +: NIBBLE_W] == '0);
            lz_blank[k] = i_lz_blank && zero_above;
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_off = phase_q ? i_blink_mask : '0;
`else
    assign blink_off = '0;
`endif

    // All blanking sources yield the same glyph, so their priority collapses to an OR.
    always_comb begin
        data_d   = i_load ? i_data : data_q;
        pend_d   = i_load;
        update_d = pend_q;
        seg_d    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!i_digit_en[k] || blink_off[k] || lz_blank[k]) begin
                seg_d[k*SEG_W +: SEG_W] = SEG_BLANK;
            end else begin
                seg_d[k*SEG_W +: SEG_W] = glyph[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q   <= '0;
            seg_q    <= '1;
            pend_q   <= 1'b0;
            update_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            seg_q    <= seg_d;
            pend_q   <= pend_d;
            update_q <= update_d;
        end
    end

    assign o_seg    = seg_q;
    assign o_update = update_q;

endmodule

// File: tb/tb_seven_segment_bank.sv
// Self-checking bench for seven_segment_bank (8 digits, BLINK_DIV=4) against a behavioural display model.
module tb_seven_segment_bank;

    localparam int N         = 8;
    localparam int BLINK_DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4*N-1:0] data;
    logic          load;
    logic          lz;
    logic [N-1:0]  en;
`ifdef SEVEN_SEG_BLINK_EN
    logic [N-1:0]  mask;
`endif
    logic [7*N-1:0] seg;
    logic          upd;

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    seven_segment_bank #(
        .NUM_DIGITS (N),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_load       (load),
        .i_lz_blank   (lz),
        .i_digit_en   (en),
`ifdef SEVEN_SEG_BLINK_EN
        .i_blink_mask (mask),
`endif
        .o_seg        (seg),
        .o_update     (upd)
    );

    // What the displays should show for a held value and the given control inputs.
    function automatic logic [7*N-1:0] model_seg(input logic [31:0] value, input logic lzb,
                                                 input logic [N-1:0] enables, input logic [N-1:0] dark);
        logic [7*N-1:0] r;
        logic [3:0]     nib;
        r = '0;
        for (int k = 0; k < N; k++) begin
            nib = value[4*k +: 4];
            if (!enables[k] || dark[k])
                r[7*k +: 7] = 7'h7F;
            else if (lzb && k > 0 && (value >> (4*k)) == 32'd0)
                r[7*k +: 7] = 7'h7F;
            else
                r[7*k +: 7] = glyph_ref[nib];
        end
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; data = '0; load = 1'b0; lz = 1'b0; en = '1;
`ifdef SEVEN_SEG_BLINK_EN
        mask = '0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (seg !== '1) $display("[TB] FAIL reset_seg: got %h expected %h", seg, {7*N{1'b1}});
        if (seg !== '1) errors++;
        checks++;
        if (upd !== 1'b0) begin errors++; $display("[TB] FAIL reset_upd: got %b expected 0", upd); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (seg !== {N{7'b1000000}}) begin
            errors++; $display("[TB] FAIL first_edge_seg: got %h expected %h", seg, {N{7'b1000000}});
        end
        checks++;
        if (upd !== 1'b0) begin errors++; $display("[TB] FAIL first_edge_upd: got %b expected 0", upd); end
    endtask

    task automatic test_lz_load;
        logic [7*N-1:0] exp_seg;
        exp_seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110};
        lz = 1'b1; en = '1;
        data = 32'h0000_1A3F; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (upd !== 1'b0) begin errors++; $display("[TB] FAIL lz_upd_early: got %b expected 0", upd); end
        @(negedge clk);
        checks++;
        if (seg !== exp_seg) begin errors++; $display("[TB] FAIL lz_1a3f_seg: got %h expected %h", seg, exp_seg); end
        checks++;
        if (upd !== 1'b1) begin errors++; $display("[TB] FAIL lz_upd_pulse: got %b expected 1", upd); end
        @(negedge clk);
        checks++;
        if (upd !== 1'b0) begin errors++; $display("[TB] FAIL lz_upd_width: got %b expected 0", upd); end
        checks++;
        if (seg !== exp_seg) begin errors++; $display("[TB] FAIL lz_1a3f_hold: got %h expected %h", seg, exp_seg); end
    endtask

    task automatic test_zero_lz;
        logic [7*N-1:0] exp_seg;
        lz = 1'b1; en = '1;
        data = 32'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        exp_seg = {{(N-1){7'h7F}}, 7'b1000000};
        checks++;
        if (seg !== exp_seg) begin errors++; $display("[TB] FAIL zero_lz_seg: got %h expected %h", seg, exp_seg); end
        lz = 1'b0;
        @(negedge clk);
        exp_seg = {N{7'b1000000}};
        checks++;
        if (seg !== exp_seg) begin errors++; $display("[TB] FAIL zero_nolz_seg: got %h expected %h", seg, exp_seg); end
    endtask

    task automatic test_digit_en;
        logic [7*N-1:0] exp_seg;
        lz = 1'b0; en = '1;
        data = 32'h8765_4321; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        exp_seg = model_seg(32'h8765_4321, 1'b0, 8'hFF, '0);
        checks++;
        if (seg !== exp_seg) begin errors++; $display("[TB] FAIL en_all_seg: got %h expected %h", seg, exp_seg); end
        en[2] = 1'b0;
        @(negedge clk);
        exp_seg = model_seg(32'h8765_4321, 1'b0, 8'hFB, '0);
        checks++;
        if (seg !== exp_seg) begin errors++; $display("[TB] FAIL en2_off_seg: got %h expected %h", seg, exp_seg); end
        checks++;
        if (seg[20:14] !== 7'h7F) begin errors++; $display("[TB] FAIL en2_digit: got %b expected 1111111", seg[20:14]); end
        en = '1;
    endtask

    task automatic test_back_to_back;
        logic exp_upd;
        logic [7*N-1:0] exp_seg;
        lz = 1'b1; en = '1;
        data = 32'd1; load = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) data = 32'd2;
            if (i == 2) data = 32'd3;
            if (i == 3) load = 1'b0;
            exp_upd = (i >= 2 && i <= 4);
            checks++;
            if (upd !== exp_upd) begin
                errors++; $display("[TB] FAIL b2b_upd[%0d]: got %b expected %b", i, upd, exp_upd);
            end
            if (i >= 2) begin
                exp_seg = model_seg((i >= 4) ? 32'd3 : 32'(i - 1), 1'b1, 8'hFF, '0);
                checks++;
                if (seg !== exp_seg) begin
                    errors++; $display("[TB] FAIL b2b_seg[%0d]: got %h expected %h", i, seg, exp_seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        lz = 1'b0; en = '1;
        data = 32'hDEAD_BEEF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== '1) begin errors++; $display("[TB] FAIL midrst_seg: got %h expected all ones", seg); end
        checks++;
        if (upd !== 1'b0) begin errors++; $display("[TB] FAIL midrst_upd: got %b expected 0", upd); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (upd !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pending: got %b expected 0", upd); end
        checks++;
        if (seg !== {N{7'b1000000}}) begin
            errors++; $display("[TB] FAIL midrst_data: got %h expected %h", seg, {N{7'b1000000}});
        end
    endtask

    // Assumes the display holds zero with nothing pending, as left by test_reset_mid.
    task automatic test_random;
        logic [31:0]    mdl_data;
        logic           mdl_pend;
        logic [7*N-1:0] exp_seg;
        logic           exp_upd;
        mdl_data = 32'd0;
        mdl_pend = 1'b0;
        for (int i = 0; i < 80; i++) begin
            data = $urandom >> $urandom_range(0, 31);
            load = 1'($urandom_range(0, 1));
            lz   = 1'($urandom_range(0, 1));
            en   = 8'($urandom | $urandom);
            exp_seg  = model_seg(mdl_data, lz, en, '0);
            exp_upd  = mdl_pend;
            mdl_pend = load;
            if (load) mdl_data = data;
            @(negedge clk);
            checks++;
            if (seg !== exp_seg) begin
                errors++; $display("[TB] FAIL rand_seg[%0d]: got %h expected %h", i, seg, exp_seg);
            end
            checks++;
            if (upd !== exp_upd) begin
                errors++; $display("[TB] FAIL rand_upd[%0d]: got %b expected %b", i, upd, exp_upd);
            end
        end
        load = 1'b0;
    endtask

`ifdef SEVEN_SEG_BLINK_EN
    // Timer restarts at reset; the phase seen by the edge n output is that set after edge n-1.
    task automatic test_blink;
        logic [7*N-1:0] exp_seg;
        logic           phase;
        lz = 1'b0; en = '1; load = 1'b0; mask = 8'h01;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            phase   = (((n - 1) / BLINK_DIV) % 2) == 1;
            exp_seg = model_seg(32'd0, 1'b0, 8'hFF, phase ? 8'h01 : 8'h00);
            checks++;
            if (seg !== exp_seg) begin
                errors++; $display("[TB] FAIL blink_seg[%0d]: got %h expected %h", n, seg, exp_seg);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== '1) begin errors++; $display("[TB] FAIL blink_rst: got %h expected all ones", seg); end
        @(negedge clk);
        mask = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        test_reset();
        test_lz_load();
        test_zero_lz();
        test_digit_en();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SEVEN_SEG_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
